// File: rtl/uart_rx_byte.sv
// -----------------------------------------------------------------------------
// uart_rx_byte
//
// Serial-to-byte receiver for the digit-recognition front end. Receives 8N1,
// LSB-first frames on an idle-high line, running on the undivided board clock.
// A good byte updates data_rx and raises rdy for RDY_STRETCH cycles, so a
// consumer on a much slower divided clock is guaranteed to see the strobe.
// Start bits that are not still low at mid-bit are rejected as glitches. A low
// stop bit sets a sticky frame_err, and the receiver then waits for the line
// to return high before hunting for the next start bit.
//
// Parameters:
//   CLKS_PER_BIT  board-clock cycles per bit (>= 4)
//   RDY_STRETCH   cycles rdy stays high after a good byte (>= 1)
//
// Ports:
//   clk        board clock
//   rst        asynchronous active-high reset
//   rx         serial input, asynchronous to clk, idle high
//   data_rx    last correctly framed byte; holds between updates
//   rdy        high for RDY_STRETCH cycles after each good byte
//   frame_err  sticky; set on a bad stop bit, cleared by a good byte or reset
//   busy       high whenever the receiver is not idle
// -----------------------------------------------------------------------------
module uart_rx_byte #(
    parameter int CLKS_PER_BIT = 868,
    parameter int RDY_STRETCH  = 2048
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data_rx,
    output logic       rdy,
    output logic       frame_err,
    output logic       busy
);

    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    // A stretch of one cycle needs only the value 0, but a signal still
    // needs at least one bit.
    localparam int STR_W  = (RDY_STRETCH > 1) ? $clog2(RDY_STRETCH) : 1;

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BAUD_W-1:0] BAUD_MID  = BAUD_W'((CLKS_PER_BIT - 1) / 2);
    localparam logic [STR_W-1:0]  STR_LOAD  = STR_W'(RDY_STRETCH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    // -------------------------------------------------------------------------
    // Input synchronizer. The flops reset to 1, the idle line level, so that
    // releasing reset can never look like a falling start edge.
    // -------------------------------------------------------------------------
    logic rx_meta;
    logic rx_s;

    // NOTE: clocked state is always assigned with <= so every flop samples
    // the pre-edge value of every other flop, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    // -------------------------------------------------------------------------
    // Registered state and datapath
    // -------------------------------------------------------------------------
    state_t            state,      state_next;
    logic [BAUD_W-1:0] baud_cnt,   baud_next;
    logic [2:0]        bit_idx,    idx_next;
    logic [7:0]        shift_reg,  shift_next;
    logic [STR_W-1:0]  str_cnt,    str_next;
    logic [7:0]        data_next;
    logic              rdy_next;
    logic              ferr_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            baud_cnt  <= '0;
            bit_idx   <= '0;
            shift_reg <= '0;
            str_cnt   <= '0;
            data_rx   <= '0;
            rdy       <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_next;
            baud_cnt  <= baud_next;
            bit_idx   <= idx_next;
            shift_reg <= shift_next;
            str_cnt   <= str_next;
            data_rx   <= data_next;
            rdy       <= rdy_next;
            frame_err <= ferr_next;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and datapath logic
    // -------------------------------------------------------------------------
    // NOTE: every signal written here gets a hold-value default first, so no
    // path through the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_next = state;
        baud_next  = baud_cnt;
        idx_next   = bit_idx;
        shift_next = shift_reg;
        str_next   = str_cnt;
        data_next  = data_rx;
        rdy_next   = rdy;
        ferr_next  = frame_err;

        // The rdy stretch runs down independently of the frame engine. A good
        // byte accepted in the STOP branch below overrides it with a reload,
        // so back-to-back bytes keep rdy continuously high.
        if (rdy) begin
            if (str_cnt == '0) begin
                rdy_next = 1'b0;
            end else begin
                str_next = str_cnt - 1'b1;
            end
        end

        case (state)
            S_IDLE: begin
                if (!rx_s) begin
                    state_next = S_START;
                    baud_next  = '0;
                end
            end

            S_START: begin
                // Re-check the line at mid start bit; a short low pulse is
                // noise and is dropped without touching any output.
                if (baud_cnt == BAUD_MID) begin
                    baud_next = '0;
                    if (!rx_s) begin
                        state_next = S_DATA;
                        idx_next   = '0;
                    end else begin
                        state_next = S_IDLE;
                    end
                end else begin
                    baud_next = baud_cnt + 1'b1;
                end
            end

            S_DATA: begin
                // Being aligned to mid start bit, a full bit period later
                // lands at mid data bit.
                if (baud_cnt == BAUD_LAST) begin
                    shift_next[bit_idx] = rx_s;
                    baud_next           = '0;
                    idx_next            = bit_idx + 1'b1;
                    if (bit_idx == 3'd7) begin
                        state_next = S_STOP;
                    end
                end else begin
                    baud_next = baud_cnt + 1'b1;
                end
            end

            S_STOP: begin
                if (baud_cnt == BAUD_LAST) begin
                    baud_next = '0;
                    if (rx_s) begin
                        data_next  = shift_reg;
                        ferr_next  = 1'b0;
                        rdy_next   = 1'b1;
                        str_next   = STR_LOAD;
                        state_next = S_IDLE;
                    end else begin
                        ferr_next  = 1'b1;
                        state_next = S_BREAK;
                    end
                end else begin
                    baud_next = baud_cnt + 1'b1;
                end
            end

            S_BREAK: begin
                // A line held low must go high again before the next start
                // bit can be recognised, so a break yields no extra bytes.
                if (rx_s) begin
                    state_next = S_IDLE;
                end
            end

            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_uart_rx_byte.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_byte
//
// Self-checking bench for uart_rx_byte. Two instances share clk and rst:
// dut (CLKS_PER_BIT=16, RDY_STRETCH=40) and dut2 (CLKS_PER_BIT=16,
// RDY_STRETCH=200, used for the back-to-back byte case). A table of frames
// with expected results drives dut, followed by hand-written sequences for
// glitch rejection, back-to-back bytes, mid-frame reset and baud skew.
// -----------------------------------------------------------------------------
module tb_uart_rx_byte;

    localparam int CPB  = 16;
    localparam int STR  = 40;
    localparam int STR2 = 200;
    localparam int HALF = 50;           // clock period is 100 time units
    localparam int GAP  = 60;           // idle cycles after each frame

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx  = 1'b1;
    logic       rx2 = 1'b1;
    logic [7:0] data_rx,   data_rx2;
    logic       rdy,       rdy2;
    logic       frame_err, frame_err2;
    logic       busy,      busy2;

    int n_checks = 0;
    int n_fail   = 0;

    uart_rx_byte #(.CLKS_PER_BIT(CPB), .RDY_STRETCH(STR)) dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .data_rx   (data_rx),
        .rdy       (rdy),
        .frame_err (frame_err),
        .busy      (busy)
    );

    uart_rx_byte #(.CLKS_PER_BIT(CPB), .RDY_STRETCH(STR2)) dut2 (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx2),
        .data_rx   (data_rx2),
        .rdy       (rdy2),
        .frame_err (frame_err2),
        .busy      (busy2)
    );

    always #HALF clk = ~clk;

    // -------------------------------------------------------------------------
    // rdy monitors: sampled just after each rising edge. They count rising
    // edges, record the cycle of the last rise and the length of the last
    // complete high run.
    // -------------------------------------------------------------------------
    int   cyc       = 0;
    int   rise_cnt  = 0;
    int   rise_cyc  = 0;
    int   run       = 0;
    int   last_len  = 0;
    int   fall_cnt2 = 0;
    int   run2      = 0;
    int   last_len2 = 0;
    logic rdy_q     = 1'b0;
    logic rdy2_q    = 1'b0;

    always @(posedge clk) begin
        #1;
        cyc++;
        if (rdy === 1'b1) begin
            if (rdy_q !== 1'b1) begin
                rise_cnt++;
                rise_cyc = cyc;
                run      = 0;
            end
            run++;
        end else if (rdy_q === 1'b1) begin
            last_len = run;
        end
        rdy_q = rdy;

        if (rdy2 === 1'b1) begin
            if (rdy2_q !== 1'b1) run2 = 0;
            run2++;
        end else if (rdy2_q === 1'b1) begin
            last_len2 = run2;
            fall_cnt2++;
        end
        rdy2_q = rdy2;
    end

    // -------------------------------------------------------------------------
    // Helpers
    // -------------------------------------------------------------------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        n_checks++;
        if (act < lo || act > hi) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_line(input bit sel, input logic v);
        if (sel) rx2 = v;
        else     rx  = v;
    endtask

    // Clock-aligned frame: each bit held exactly CPB cycles, driven at negedge.
    task automatic send_frame(input logic [7:0] d, input logic stop, input bit sel);
        set_line(sel, 1'b0);
        cycles(CPB);
        for (int i = 0; i < 8; i++) begin
            set_line(sel, d[i]);
            cycles(CPB);
        end
        set_line(sel, stop);
        cycles(CPB);
    endtask

    // Free-running frame with an arbitrary bit time, asynchronous to clk.
    task automatic send_skew(input logic [7:0] d, input int bit_t);
        rx = 1'b0;
        #(bit_t);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            #(bit_t);
        end
        rx = 1'b1;
        #(bit_t);
    endtask

    // -------------------------------------------------------------------------
    // Frame table
    // -------------------------------------------------------------------------
    typedef struct {
        logic [7:0] data;
        logic       stop;
        int         hold;       // extra low cycles after a bad stop bit
        logic [7:0] exp_data;
        logic       exp_ferr;
        int         exp_rise;   // rdy rising edges expected for this frame
    } vec_t;

    vec_t vecs [6];

    // -------------------------------------------------------------------------
    // Test sequence
    // -------------------------------------------------------------------------
    initial begin
        int         r0;
        int         n0;
        int         f0;
        logic [7:0] d;
        int         bt;

        vecs[0] = '{data: 8'hA5, stop: 1'b1, hold: 0,  exp_data: 8'hA5, exp_ferr: 1'b0, exp_rise: 1};
        vecs[1] = '{data: 8'h3C, stop: 1'b0, hold: 50, exp_data: 8'hA5, exp_ferr: 1'b1, exp_rise: 0};
        vecs[2] = '{data: 8'h07, stop: 1'b1, hold: 0,  exp_data: 8'h07, exp_ferr: 1'b0, exp_rise: 1};
        vecs[3] = '{data: 8'hFF, stop: 1'b1, hold: 0,  exp_data: 8'hFF, exp_ferr: 1'b0, exp_rise: 1};
        vecs[4] = '{data: 8'h80, stop: 1'b0, hold: 0,  exp_data: 8'hFF, exp_ferr: 1'b1, exp_rise: 0};
        vecs[5] = '{data: 8'h5A, stop: 1'b1, hold: 0,  exp_data: 8'h5A, exp_ferr: 1'b0, exp_rise: 1};

        // Reset state
        cycles(3);
        check("reset_data",  32'(data_rx),   32'h00);
        check("reset_rdy",   32'(rdy),       32'h0);
        check("reset_ferr",  32'(frame_err), 32'h0);
        check("reset_busy",  32'(busy),      32'h0);
        check("reset_data2", 32'(data_rx2),  32'h00);
        rst = 1'b0;
        cycles(5);
        check("release_busy", 32'(busy), 32'h0);

        // Table-driven frames. The pin falls at the negedge that ends cycle
        // n0; the first rising edge to see it is n0+1. rdy must rise
        // 2 + 7 + 9*16 = 153 (+/-1) cycles after that.
        for (int i = 0; i < 6; i++) begin
            r0 = rise_cnt;
            n0 = cyc;
            send_frame(vecs[i].data, vecs[i].stop, 1'b0);
            if (!vecs[i].stop) begin
                cycles(vecs[i].hold);
                check($sformatf("v%0d_busy_break", i), 32'(busy),      32'h1);
                check($sformatf("v%0d_ferr_break", i), 32'(frame_err), 32'h1);
            end
            rx = 1'b1;
            cycles(GAP);
            check($sformatf("v%0d_data", i), 32'(data_rx),      32'(vecs[i].exp_data));
            check($sformatf("v%0d_ferr", i), 32'(frame_err),    32'(vecs[i].exp_ferr));
            check($sformatf("v%0d_rise", i), 32'(rise_cnt - r0), 32'(vecs[i].exp_rise));
            check($sformatf("v%0d_busy", i), 32'(busy),         32'h0);
            check($sformatf("v%0d_rdy",  i), 32'(rdy),          32'h0);
            if (vecs[i].exp_rise == 1) begin
                check($sformatf("v%0d_rdy_len", i), 32'(last_len), 32'(STR));
                check_range($sformatf("v%0d_latency", i), rise_cyc - n0 - 1, 152, 154);
            end
        end

        // Glitch: 5-cycle low pulse is rejected at mid start bit.
        r0 = rise_cnt;
        rx = 1'b0;
        cycles(4);
        check("glitch_busy_start", 32'(busy), 32'h1);
        cycles(1);
        rx = 1'b1;
        cycles(10);
        check("glitch_busy_end", 32'(busy),          32'h0);
        check("glitch_data",     32'(data_rx),       32'h5A);
        check("glitch_ferr",     32'(frame_err),     32'h0);
        check("glitch_rise",     32'(rise_cnt - r0), 32'h0);

        // Back-to-back bytes on dut2: rdy must stay high across both, then
        // fall 200 cycles after the second byte. The loads are 160 cycles
        // apart, so the whole high run is 160 + 200 cycles.
        f0 = fall_cnt2;
        send_frame(8'h01, 1'b1, 1'b1);
        check("b2b_first_data", 32'(data_rx2), 32'h01);
        check("b2b_first_rdy",  32'(rdy2),     32'h1);
        send_frame(8'h02, 1'b1, 1'b1);
        check("b2b_second_data", 32'(data_rx2),      32'h02);
        check("b2b_second_rdy",  32'(rdy2),          32'h1);
        check("b2b_no_drop",     32'(fall_cnt2 - f0), 32'h0);
        cycles(300);
        check("b2b_rdy_low",  32'(rdy2),           32'h0);
        check("b2b_one_fall", 32'(fall_cnt2 - f0), 32'h1);
        check("b2b_run_len",  32'(last_len2),      32'(CPB * 10 + STR2));
        check("b2b_ferr",     32'(frame_err2),     32'h0);

        // Reset in the middle of data bit 4 of 8'hFF.
        rx = 1'b0;
        cycles(CPB);
        rx = 1'b1;
        cycles(CPB * 4 + CPB / 2);
        check("mid_busy", 32'(busy), 32'h1);
        rst = 1'b1;
        #1;
        check("rst_async_busy", 32'(busy),      32'h0);
        check("rst_async_data", 32'(data_rx),   32'h00);
        check("rst_async_rdy",  32'(rdy),       32'h0);
        check("rst_async_ferr", 32'(frame_err), 32'h0);
        cycles(20);
        rst = 1'b0;
        cycles(5);
        check("rst_rel_busy", 32'(busy),    32'h0);
        check("rst_rel_data", 32'(data_rx), 32'h00);
        r0 = rise_cnt;
        send_frame(8'h5A, 1'b1, 1'b0);
        rx = 1'b1;
        cycles(GAP);
        check("rst_next_data", 32'(data_rx),       32'h5A);
        check("rst_next_ferr", 32'(frame_err),     32'h0);
        check("rst_next_rise", 32'(rise_cnt - r0), 32'h1);

        // Random bytes with -3%, 0 and +3% bit time, asynchronous to clk.
        for (int i = 0; i < 9; i++) begin
            d  = 8'($urandom_range(0, 255));
            bt = (i % 3 == 0) ? 1552 : ((i % 3 == 1) ? 1600 : 1648);
            r0 = rise_cnt;
            @(negedge clk);
            #13;
            send_skew(d, bt);
            cycles(GAP);
            check($sformatf("skew%0d_data", i), 32'(data_rx),       32'(d));
            check($sformatf("skew%0d_ferr", i), 32'(frame_err),     32'h0);
            check($sformatf("skew%0d_rise", i), 32'(rise_cnt - r0), 32'h1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
